wb_gpio_bank: RTL

WB_GPIO_BANK -- requirements
Module: wb_gpio_bank

---
 rtl/wb_gpio_bank_pkg.sv | 32 +++
 rtl/wb_gpio_bank_if.sv | 24 ++
 rtl/wb_gpio_bank_sync.sv | 30 +++
 rtl/wb_gpio_bank.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/wb_gpio_bank_pkg.sv
// wb_gpio_pkg: shared definitions for the wb_gpio_bank GPIO block.
//   - byte offsets of the register map
//   - reg_idx_e: register index as decoded from wbs_adr_i[4:2]
//   - sel_mask(): expands a 4-bit Wishbone byte select into a 32-bit bit mask
package wb_gpio_pkg;

  localparam logic [7:0] OFF_DATA_IN  = 8'h00;
  localparam logic [7:0] OFF_DATA_OUT = 8'h04;
  localparam logic [7:0] OFF_OE       = 8'h08;
  localparam logic [7:0] OFF_IRQ_EN   = 8'h0C;
  localparam logic [7:0] OFF_IRQ_POL  = 8'h10;
  localparam logic [7:0] OFF_IRQ_STAT = 8'h14;

  // Word index of each register (offset >> 2); indices 6 and 7 are unmapped.
  typedef enum logic [2:0] {
    REG_DATA_IN  = 3'd0,
    REG_DATA_OUT = 3'd1,
    REG_OE       = 3'd2,
    REG_IRQ_EN   = 3'd3,
    REG_IRQ_POL  = 3'd4,
    REG_IRQ_STAT = 3'd5
  } reg_idx_e;

  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int unsigned i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_gpio_bank_if.sv
// wb_gpio_if: Wishbone classic slave bundle for wb_gpio_bank.
//   master modport: drives cyc/stb/we/sel/adr/dat_i, receives ack/dat_o
//   slave  modport: the reverse
// Signal names match the wb_gpio_bank ports one-to-one.
interface wb_gpio_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_gpio_bank_sync.sv
// gpio_sync: SYNC_STAGES-deep flop chain bringing asynchronous pad inputs
// into the clk domain.
//   clk, rst_n : clock, asynchronous active-low reset (chain clears to 0)
//   d          : asynchronous input bus, WIDTH bits
//   q          : synchronized output (last stage)
module gpio_sync #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q, stage_d;

  // Stage 0 captures the pad; each later stage takes its predecessor.
  always_comb begin
    stage_d = {stage_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/wb_gpio_bank.sv
// wb_gpio_bank: Wishbone classic GPIO bank with optional edge interrupts.
//   wb_clk_i / wb_rst_ni : clock, asynchronous active-low reset
//   wbs_*                : Wishbone classic slave (one-cycle registered ack)
//   io_in                : asynchronous pad inputs (synchronized internally)
//   io_out / io_oeb      : pad output values / active-low output enables
//   irq                  : level interrupt, OR of IRQ_STAT bits
// Register map (adr[4:2]): DATA_IN RO, DATA_OUT, OE, IRQ_EN, IRQ_POL,
// IRQ_STAT (W1C); other offsets read 0.
// Build option: define GPIO_IRQ_EN to include the interrupt logic; without it
// the IRQ registers read 0, ignore writes and irq is tied low.
module wb_gpio_bank
  import wb_gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_oeb,
  output logic             irq
);

  function automatic logic [31:0] widen(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r            = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  logic [WIDTH-1:0] sync_in;

  gpio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (wb_clk_i),
    .rst_n(wb_rst_ni),
    .d    (io_in),
    .q    (sync_in)
  );

  // ---------------------------------------------------------------- bus side
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic             access, wr;
  reg_idx_e         idx;
  logic [31:0]      lane_mask;
  logic [WIDTH-1:0] wmask, wdata;
  logic [WIDTH-1:0] irq_en, irq_pol, irq_stat;
  logic [31:0]      rd_data;

  // A new access is accepted only while ack is low, so held strobes ack
  // every second cycle.
  assign access    = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr        = access & wbs_we_i;
  assign idx       = reg_idx_e'(wbs_adr_i[4:2]);
  assign lane_mask = sel_mask(wbs_sel_i);
  assign wmask     = lane_mask[WIDTH-1:0];
  assign wdata     = wbs_dat_i[WIDTH-1:0];

  always_comb begin
    rd_data = '0;
    case (idx)
      REG_DATA_IN:  rd_data = widen(sync_in);
      REG_DATA_OUT: rd_data = widen(out_q);
      REG_OE:       rd_data = widen(oe_q);
      REG_IRQ_EN:   rd_data = widen(irq_en);
      REG_IRQ_POL:  rd_data = widen(irq_pol);
      REG_IRQ_STAT: rd_data = widen(irq_stat);
      default:      rd_data = '0;
    endcase
  end

  always_comb begin
    ack_d = access;
    dat_d = access ? rd_data : '0;
    out_d = out_q;
    oe_d  = oe_q;
    if (wr && idx == REG_DATA_OUT) out_d = (out_q & ~wmask) | (wdata & wmask);
    if (wr && idx == REG_OE)       oe_d  = (oe_q  & ~wmask) | (wdata & wmask);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      out_q <= '0;
      oe_q  <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      out_q <= out_d;
      oe_q  <= oe_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = out_q;
  assign io_oeb    = ~oe_q;

  // ---------------------------------------------------------- interrupt side
`ifdef GPIO_IRQ_EN
  localparam logic [2:0] SETTLE_CYCLES = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] en_q, en_d, pol_q, pol_d, stat_q, stat_d, prev_q, prev_d;
  logic [WIDTH-1:0] clr, rise, fall, hit;
  logic [2:0]       settle_q, settle_d;
  logic             settled;

  // Edges are ignored until the synchronizer and delayed copy have flushed
  // the reset zeros, so pins high at reset release raise nothing.
  assign settled = (settle_q == SETTLE_CYCLES);

  always_comb begin
    en_d     = en_q;
    pol_d    = pol_q;
    prev_d   = sync_in;
    settle_d = settled ? settle_q : settle_q + 3'd1;
    if (wr && idx == REG_IRQ_EN)  en_d  = (en_q  & ~wmask) | (wdata & wmask);
    if (wr && idx == REG_IRQ_POL) pol_d = (pol_q & ~wmask) | (wdata & wmask);
    clr  = (wr && idx == REG_IRQ_STAT) ? (wdata & wmask) : '0;
    rise = sync_in & ~prev_q;
    fall = ~sync_in & prev_q;
    hit  = ((pol_q & rise) | (~pol_q & fall)) & en_q;
    if (!settled) hit = '0;
    // Set applied after clear: a hardware edge wins over a same-cycle W1C.
    stat_d = (stat_q & ~clr) | hit;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      en_q     <= '0;
      pol_q    <= '0;
      stat_q   <= '0;
      prev_q   <= '0;
      settle_q <= '0;
    end else begin
      en_q     <= en_d;
      pol_q    <= pol_d;
      stat_q   <= stat_d;
      prev_q   <= prev_d;
      settle_q <= settle_d;
    end
  end

  assign irq_en   = en_q;
  assign irq_pol  = pol_q;
  assign irq_stat = stat_q;
  assign irq      = |stat_q;
`else
  assign irq_en   = '0;
  assign irq_pol  = '0;
  assign irq_stat = '0;
  assign irq      = 1'b0;
`endif

  // Address/data bits outside the decoded range are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_dat_i, lane_mask};

endmodule
